// File: rtl/wram_dma_if.sv
// RV-side memory request port of the SDRAM arbiter: toggle request/acknowledge pair
// with byte address, strobes, write data and read data.
`timescale 1ns/1ps

interface wram_dma_if;
    logic [22:0] rv_addr;
    logic        rv_word;
    logic [15:0] rv_din;
    logic [1:0]  rv_ds;
    logic        rv_we;
    logic        rv_req;
    logic        rv_req_ack;
    logic [15:0] rv_dout;

    modport master (
        output rv_addr, rv_word, rv_din, rv_ds, rv_we, rv_req,
        input  rv_req_ack, rv_dout
    );

    modport slave (
        input  rv_addr, rv_word, rv_din, rv_ds, rv_we, rv_req,
        output rv_req_ack, rv_dout
    );
endinterface

// File: rtl/wram_dma.sv
// Save/load sequencer moving the WRAM window between byte streams and the arbiter RV port.
// Optional running byte checksum on o_checksum when WRAM_DMA_CHECKSUM_EN is defined.
`timescale 1ns/1ps

module wram_dma #(
    parameter logic [22:0] BASE_ADDR = 23'h66000,
    parameter int          LEN_BYTES = 8192
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        i_start,
    input  logic        i_dir,
    input  logic        i_abort,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_wram_load_ongoing,
    output logic [7:0]  o_tx_data,
    output logic        o_tx_valid,
    input  logic        i_tx_ready,
    input  logic [7:0]  i_rx_data,
    input  logic        i_rx_valid,
    output logic        o_rx_ready,
    wram_dma_if.master  rv,
    output logic [15:0] o_checksum,
    output logic [3:0]  dbg_state
);
    localparam int WORDS  = LEN_BYTES / 2;
    localparam int WCNT_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [WCNT_W-1:0] LAST_WORD = WCNT_W'(WORDS - 1);

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        RD_REQ   = 4'd1,
        RD_WAIT  = 4'd2,
        RD_CAP   = 4'd3,
        EMIT0    = 4'd4,
        EMIT1    = 4'd5,
        COLLECT0 = 4'd6,
        COLLECT1 = 4'd7,
        WR_REQ   = 4'd8,
        WR_WAIT  = 4'd9,
        DONE     = 4'd10
    } state_t;

    state_t            state, state_d;
    logic              dir_q, abort_q;
    logic [WCNT_W-1:0] wcnt;
    logic [15:0]       word_q;
    logic [22:0]       addr_q;
    logic [15:0]       din_q;
    logic [1:0]        ds_q;
    logic              we_q, req_q;
    logic              acked, last_word, abort_now, start_ok;
    logic              issue, wcnt_inc, tx_fire, rx_fire;

    // Byte streams: a byte moves on every rising edge where valid and ready are both
    // high; the producer holds data steady while valid is high and ready is low.
    assign o_tx_valid = (state == EMIT0) || (state == EMIT1);
    assign o_tx_data  = (state == EMIT1) ? word_q[15:8] : word_q[7:0];
    assign o_rx_ready = (state == COLLECT0) || (state == COLLECT1);
    assign tx_fire    = o_tx_valid && i_tx_ready;
    assign rx_fire    = o_rx_ready && i_rx_valid;

    assign acked     = (rv.rv_req_ack == req_q);
    assign last_word = (wcnt == LAST_WORD);
    assign abort_now = i_abort || abort_q;
    assign start_ok  = (state == IDLE) && i_start;

    assign o_busy              = (state != IDLE);
    assign o_done              = (state == DONE);
    assign o_wram_load_ongoing = o_busy && dir_q;
    assign dbg_state           = state;

    assign rv.rv_addr = addr_q;
    assign rv.rv_word = addr_q[1];
    assign rv.rv_din  = din_q;
    assign rv.rv_ds   = ds_q;
    assign rv.rv_we   = we_q;
    assign rv.rv_req  = req_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_d;
    end

    always_comb begin
        state_d  = state;
        issue    = 1'b0;
        wcnt_inc = 1'b0;
        case (state)
            IDLE:     if (i_start) state_d = i_dir ? COLLECT0 : RD_REQ;
            RD_REQ: begin
                issue   = 1'b1;
                state_d = RD_WAIT;
            end
            RD_WAIT:  if (acked) state_d = abort_now ? DONE : RD_CAP;
            RD_CAP:   state_d = abort_now ? DONE : EMIT0;
            EMIT0: begin
                if (i_abort)      state_d = DONE;
                else if (tx_fire) state_d = EMIT1;
            end
            EMIT1: begin
                if (i_abort) state_d = DONE;
                else if (tx_fire) begin
                    if (last_word) state_d = DONE;
                    else begin
                        state_d  = RD_REQ;
                        wcnt_inc = 1'b1;
                    end
                end
            end
            COLLECT0: begin
                if (i_abort)      state_d = DONE;
                else if (rx_fire) state_d = COLLECT1;
            end
            COLLECT1: begin
                if (i_abort)      state_d = DONE;
                else if (rx_fire) state_d = WR_REQ;
            end
            WR_REQ: begin
                issue   = 1'b1;
                state_d = WR_WAIT;
            end
            WR_WAIT: begin
                if (acked) begin
                    if (abort_now || last_word) state_d = DONE;
                    else begin
                        state_d  = COLLECT0;
                        wcnt_inc = 1'b1;
                    end
                end
            end
            DONE:     state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // Address, data and we are registered together with the req toggle so they are
    // already stable in the first cycle the arbiter can see the new request.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            dir_q   <= 1'b0;
            abort_q <= 1'b0;
            wcnt    <= '0;
            word_q  <= '0;
            addr_q  <= '0;
            din_q   <= '0;
            ds_q    <= '0;
            we_q    <= 1'b0;
            req_q   <= 1'b0;
        end else begin
            if (start_ok) begin
                dir_q <= i_dir;
                wcnt  <= '0;
            end else if (wcnt_inc) begin
                wcnt <= wcnt + WCNT_W'(1);
            end
            abort_q <= (state == IDLE || state == DONE) ? 1'b0 : (abort_q || i_abort);
            if (state == RD_CAP)                  word_q       <= rv.rv_dout;
            else if (rx_fire && state == COLLECT0) word_q[7:0]  <= i_rx_data;
            else if (rx_fire && state == COLLECT1) word_q[15:8] <= i_rx_data;
            if (issue) begin
                req_q  <= ~req_q;
                addr_q <= BASE_ADDR + (23'(wcnt) << 1);
                we_q   <= (state == WR_REQ);
                din_q  <= word_q;
                ds_q   <= 2'b11;
            end
        end
    end

`ifdef WRAM_DMA_CHECKSUM_EN
    logic [15:0] csum_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)      csum_q <= '0;
        else if (start_ok) csum_q <= '0;
        else if (tx_fire)  csum_q <= csum_q + {8'h00, o_tx_data};
        else if (rx_fire)  csum_q <= csum_q + {8'h00, i_rx_data};
    end

    assign o_checksum = csum_q;
`else
    assign o_checksum = 16'h0000;
`endif
endmodule

// File: tb/tb_wram_dma.sv
// Directed bench for wram_dma: toggle-ack memory model with configurable latency,
// byte sink/source models, expected queues for streamed bytes and written words.
`timescale 1ns/1ps

module tb_wram_dma;
    localparam logic [22:0] BASE = 23'h66000;
    localparam int          NWORDS = 4096;
    localparam logic [3:0]  ST_IDLE = 4'd0, ST_RD_WAIT = 4'd2, ST_WR_WAIT = 4'd9;

    // clock / reset
    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    logic        i_start, i_dir, i_abort;
    logic        o_busy, o_done, o_wram_load_ongoing;
    logic [7:0]  o_tx_data;
    logic        o_tx_valid, i_tx_ready;
    logic [7:0]  i_rx_data;
    logic        i_rx_valid, o_rx_ready;
    logic [15:0] o_checksum;
    logic [3:0]  dbg_state;

    wram_dma_if rv_bus();

    wram_dma dut (
        .clk                 (clk),
        .resetn              (resetn),
        .i_start             (i_start),
        .i_dir               (i_dir),
        .i_abort             (i_abort),
        .o_busy              (o_busy),
        .o_done              (o_done),
        .o_wram_load_ongoing (o_wram_load_ongoing),
        .o_tx_data           (o_tx_data),
        .o_tx_valid          (o_tx_valid),
        .i_tx_ready          (i_tx_ready),
        .i_rx_data           (i_rx_data),
        .i_rx_valid          (i_rx_valid),
        .o_rx_ready          (o_rx_ready),
        .rv                  (rv_bus),
        .o_checksum          (o_checksum),
        .dbg_state           (dbg_state)
    );

    // scoreboard state
    int n_tests = 0;
    int n_fail  = 0;
    logic [7:0]  exp_q[$];
    logic [38:0] wexp_q[$];

    int ack_lat = 1, mem_mode = 0, sink_mode = 0;
    logic load_mode = 1'b0;
    int n_req, n_wr_issue, n_wr_done, n_ack, n_toggle, proto_err, cnt;
    int tx_count, busy_cycles, done_cnt, lo_err, lo_cycles;
    bit pending, first_seen, sink_fire, src_fire;
    logic        last_req;
    logic [22:0] pend_addr, first_addr;
    logic [38:0] first_wr, last_wr, wr_now;
    logic [7:0]  tx_first [0:3];
    logic [7:0]  e_byte;
    logic [15:0] csum_exp;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] mem_word(input logic [22:0] a);
        if (mem_mode == 1) return 16'hFFFF;
        if (a == 23'h66000) return 16'hBEEF;
        if (a == 23'h66002) return 16'h1234;
        return {a[8:1], ~a[8:1]};
    endfunction

    function automatic logic [15:0] csum_ref();
`ifdef WRAM_DMA_CHECKSUM_EN
        return csum_exp;
`else
        return 16'h0000;
`endif
    endfunction

    // memory model: acks a toggle ack_lat cycles later; read data appears with the ack
    always @(negedge clk or negedge resetn) begin
        if (!resetn) begin
            rv_bus.rv_req_ack = 1'b0;
            rv_bus.rv_dout    = 16'h0000;
            pending  = 0;
            last_req = 1'b0;
            n_toggle = 0;
            n_ack    = 0;
        end else begin
            if (rv_bus.rv_req !== last_req) begin
                n_toggle++;
                last_req = rv_bus.rv_req;
                if (n_toggle - n_ack > 1) proto_err++;
                if (rv_bus.rv_ds !== 2'b11 || rv_bus.rv_word !== rv_bus.rv_addr[1]) proto_err++;
                if (!first_seen) begin
                    first_seen = 1;
                    first_addr = rv_bus.rv_addr;
                end
                pending   = 1;
                cnt       = 0;
                n_req++;
                pend_addr = rv_bus.rv_addr;
                rv_bus.rv_dout = 16'hDEAD;
                if (rv_bus.rv_we) n_wr_issue++;
            end
            if (pending) begin
                if (rv_bus.rv_addr !== pend_addr) proto_err++;
                cnt++;
                if (cnt >= ack_lat) begin
                    pending = 0;
                    n_ack++;
                    rv_bus.rv_req_ack = rv_bus.rv_req;
                    if (rv_bus.rv_we) begin
                        n_wr_done++;
                        wr_now = {rv_bus.rv_addr, rv_bus.rv_din};
                        if (n_wr_done == 1) first_wr = wr_now;
                        last_wr = wr_now;
                        if (wexp_q.size() == 0) check("wr_extra", 1, 0);
                        else check("wr_word", wr_now, wexp_q.pop_front());
                    end else begin
                        rv_bus.rv_dout = mem_word(rv_bus.rv_addr);
                    end
                end
            end
        end
    end

    // stream sink/source and status monitor
    always begin
        @(negedge clk);
        sink_fire = o_tx_valid && i_tx_ready;
        src_fire  = o_rx_ready && i_rx_valid;
        if (sink_fire) begin
            if (tx_count < 4) tx_first[tx_count] = o_tx_data;
            tx_count++;
            if (exp_q.size() == 0) check("tx_extra", 1, 0);
            else begin
                e_byte = exp_q.pop_front();
                csum_exp += {8'h00, e_byte};
                check("tx_byte", o_tx_data, e_byte);
            end
        end
        if (src_fire) csum_exp += {8'h00, i_rx_data};
        if (o_wram_load_ongoing !== (o_busy && load_mode)) lo_err++;
        if (o_wram_load_ongoing) lo_cycles++;
        if (o_busy) busy_cycles++;
        if (o_done) done_cnt++;
        @(posedge clk);
        #1;
        if (src_fire) i_rx_data = i_rx_data + 8'd1;
        i_tx_ready = (sink_mode == 1) ? ~i_tx_ready : 1'b1;
    end

    // driver tasks
    task automatic clear_stats();
        n_req = 0; n_wr_issue = 0; n_wr_done = 0; proto_err = 0; first_seen = 0;
        tx_count = 0; busy_cycles = 0; done_cnt = 0; lo_err = 0; lo_cycles = 0;
        csum_exp = 16'h0000;
        exp_q.delete();
        wexp_q.delete();
    endtask

    task automatic fill_save_exp();
        logic [15:0] w;
        for (int i = 0; i < NWORDS; i++) begin
            w = mem_word(BASE + 23'(2 * i));
            exp_q.push_back(w[7:0]);
            exp_q.push_back(w[15:8]);
        end
    endtask

    task automatic fill_load_exp();
        logic [7:0] lo, hi;
        for (int i = 0; i < NWORDS; i++) begin
            lo = 8'((2 * i) % 256);
            hi = 8'((2 * i + 1) % 256);
            wexp_q.push_back({BASE + 23'(2 * i), hi, lo});
        end
    endtask

    task automatic start_xfer(input logic dir);
        load_mode = dir;
        @(negedge clk); #2;
        check("idle_before_start", o_busy, 0);
        i_start = 1'b1;
        i_dir   = dir;
        @(negedge clk); #2;
        i_start = 1'b0;
        i_dir   = ~dir;
        check("busy_rise", o_busy, 1);
    endtask

    task automatic pulse_abort();
        i_abort = 1'b1;
        @(negedge clk); #2;
        i_abort = 1'b0;
    endtask

    task automatic wait_done(input int limit);
        int k = 0;
        while (!(done_cnt > 0 && !o_busy) && k <= limit) begin
            @(negedge clk); #2;
            k++;
        end
        if (k > limit) check("done_timeout", k, limit);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_busy"}, o_busy, 0);
        check({tag, "_done"}, o_done, 0);
        check({tag, "_load_ongoing"}, o_wram_load_ongoing, 0);
        check({tag, "_tx"}, {o_tx_valid, o_tx_data}, 0);
        check({tag, "_rx_ready"}, o_rx_ready, 0);
        check({tag, "_rv_addr"}, {rv_bus.rv_addr, rv_bus.rv_word}, 0);
        check({tag, "_rv_din"}, rv_bus.rv_din, 0);
        check({tag, "_rv_ctl"}, {rv_bus.rv_ds, rv_bus.rv_we, rv_bus.rv_req}, 0);
        check({tag, "_checksum"}, o_checksum, 0);
        check({tag, "_state"}, dbg_state, ST_IDLE);
    endtask

    task automatic check_end(input string tag);
        check({tag, "_done_pulses"}, done_cnt, 1);
        check({tag, "_req_eq_ack"}, rv_bus.rv_req, rv_bus.rv_req_ack);
        check({tag, "_protocol"}, proto_err, 0);
        check({tag, "_load_flag"}, lo_err, 0);
        check({tag, "_checksum"}, o_checksum, csum_ref());
    endtask

    task automatic check_first_bytes(input string tag);
        check({tag, "_first_addr"}, first_addr, 23'h66000);
        check({tag, "_b0"}, tx_first[0], 8'hEF);
        check({tag, "_b1"}, tx_first[1], 8'hBE);
        check({tag, "_b2"}, tx_first[2], 8'h34);
        check({tag, "_b3"}, tx_first[3], 8'h12);
    endtask

    initial begin
        int k;
        i_start = 1'b0; i_dir = 1'b0; i_abort = 1'b0;
        i_tx_ready = 1'b1; i_rx_valid = 1'b0; i_rx_data = 8'h00;
        clear_stats();
        repeat (3) @(negedge clk);
        #2;
        check_zero("reset");
        resetn = 1'b1;

        // full save, fast ack, sink always ready
        mem_mode = 0; ack_lat = 1; sink_mode = 0;
        clear_stats(); fill_save_exp();
        start_xfer(1'b0);
        wait_done(30000);
        check_first_bytes("save");
        check("save_bytes", tx_count, 8192);
        check("save_words", n_req, 4096);
        check("save_left", exp_q.size(), 0);
        check("save_cycles", busy_cycles, 4096 * 5 + 1);
        check_end("save");

        // full load, source always valid with 00,01,..,FF repeating
        ack_lat = 1; i_rx_data = 8'h00; i_rx_valid = 1'b1;
        clear_stats(); fill_load_exp();
        start_xfer(1'b1);
        wait_done(30000);
        i_rx_valid = 1'b0;
        check("load_writes", n_wr_done, 4096);
        check("load_first_wr", first_wr, {23'h66000, 16'h0100});
        check("load_last_wr", last_wr, {23'h67FFE, 16'hFFFE});
        check("load_left", wexp_q.size(), 0);
        check("load_cycles", busy_cycles, 4096 * 4 + 1);
        check("load_flag_cycles", lo_cycles, 4096 * 4 + 1);
        check_end("load");

        // abort while idle does nothing
        @(negedge clk); #2;
        pulse_abort();
        @(negedge clk); #2;
        check("abort_idle_busy", o_busy, 0);
        check("abort_idle_state", dbg_state, ST_IDLE);

        // backpressure: sink ready alternating, ack latency 7, abort in RD_WAIT of word 40
        ack_lat = 7; sink_mode = 1;
        clear_stats(); fill_save_exp();
        start_xfer(1'b0);
        k = 0;
        while (!(n_req == 41 && dbg_state == ST_RD_WAIT) && k < 5000) begin
            @(negedge clk); #2;
            k++;
        end
        check("bp_reach_word40", k < 5000, 1);
        pulse_abort();
        wait_done(1000);
        check("bp_bytes", tx_count, 80);
        check("bp_reqs", n_req, 41);
        check_end("bp");
        sink_mode = 0;

        // load abort in WR_WAIT of word 5, with a start pulse ignored mid-transfer
        ack_lat = 3; i_rx_data = 8'h00; i_rx_valid = 1'b1;
        clear_stats(); fill_load_exp();
        start_xfer(1'b1);
        k = 0;
        while (n_wr_issue < 2 && k < 500) begin
            @(negedge clk); #2;
            k++;
        end
        i_start = 1'b1; i_dir = 1'b0;
        @(negedge clk); #2;
        i_start = 1'b0;
        @(negedge clk); #2;
        check("busy_start_ignored", o_wram_load_ongoing, 1);
        k = 0;
        while (!(n_wr_issue == 6 && dbg_state == ST_WR_WAIT) && k < 500) begin
            @(negedge clk); #2;
            k++;
        end
        check("abort_reach_word5", k < 500, 1);
        pulse_abort();
        wait_done(500);
        i_rx_valid = 1'b0;
        check("abort_writes", n_wr_done, 6);
        check_end("abort");

        // reset in RD_WAIT, then a fresh save starts again from word 0
        ack_lat = 7;
        clear_stats(); fill_save_exp();
        start_xfer(1'b0);
        k = 0;
        while (dbg_state != ST_RD_WAIT && k < 100) begin
            @(negedge clk); #2;
            k++;
        end
        check("rst_reach_wait", dbg_state, ST_RD_WAIT);
        resetn = 1'b0;
        #1;
        check_zero("rst_mid");
        @(negedge clk); #2;
        resetn = 1'b1;
        ack_lat = 1;
        clear_stats(); fill_save_exp();
        start_xfer(1'b0);
        k = 0;
        while (tx_count < 4 && k < 200) begin
            @(negedge clk); #2;
            k++;
        end
        pulse_abort();
        wait_done(200);
        check_first_bytes("rst_again");
        check("rst_again_bytes", tx_count, 4);
        check("rst_again_reqs", n_req, 2);
        check_end("rst_again");

        // full save of all-0xFF memory: checksum 8192*255 mod 2^16
        mem_mode = 1; ack_lat = 1;
        clear_stats(); fill_save_exp();
        start_xfer(1'b0);
        wait_done(30000);
        check("ff_bytes", tx_count, 8192);
        check("ff_left", exp_q.size(), 0);
`ifdef WRAM_DMA_CHECKSUM_EN
        check("ff_checksum", o_checksum, 16'hE000);
`else
        check("ff_checksum", o_checksum, 16'h0000);
`endif
        repeat (3) @(negedge clk);
        #2;
        check_end("ff");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/wram_dma.md
# wram_dma

Sequencing initiator for the RISC-V side of the SDRAM arbiter's memory port. On command it moves the 8 KB WRAM window, RV byte addresses 0x66000–0x67FFF, in one of two directions:
- Save: reads 16-bit words from the window and streams out bytes.
- Load: collects incoming bytes, writes them back as words, and raises `o_wram_load_ongoing` so the arbiter gives the RV port WRAM priority.

It sits between the save-state/SD controller (byte streams) and the arbiter's `rv_*` request port.

## Interface
Parameters:
- `BASE_ADDR`, 23'h66000: first byte address of the window; must be 4-byte aligned.
- `LEN_BYTES`, 8192: window length; even, power of two, at most 65536.

Ports:
- Clock and reset (already decided): one clock; reset is asynchronous and active-low. The ports are:
  - `clk`, in, 1: single clock.
  - `resetn`, in, 1: asynchronous, active-low reset.
- Command:
  - `i_start`, in, 1: one-cycle start pulse; ignored unless idle.
  - `i_dir`, in, 1: sampled at start; 0 = save, 1 = load.
  - `i_abort`, in, 1: stop after the in-flight request completes.
  - `o_busy`, out, 1: transfer in progress.
  - `o_done`, out, 1: one-cycle pulse at completion or abort.
  - `o_wram_load_ongoing`, out, 1: high for the whole of a load.
- Byte streams:
  - `o_tx_data`, out, 8; `o_tx_valid`, out, 1; `i_tx_ready`, in, 1: save stream out.
  - `i_rx_data`, in, 8; `i_rx_valid`, in, 1; `o_rx_ready`, out, 1: load stream in.
- RV memory port:
  - `rv_addr`, out, 23: byte address of the word.
  - `rv_word`, out, 1: equals `rv_addr[1]`.
  - `rv_din`, out, 16: write data.
  - `rv_ds`, out, 2: byte strobes; always 2'b11.
  - `rv_we`, out, 1: write enable.
  - `rv_req`, out, 1: request toggle.
  - `rv_req_ack`, in, 1: acknowledge toggle.
  - `rv_dout`, in, 16: read data.
- Checksum:
  - `o_checksum`, out, 16: see Configuration.

## Operation
- Handshake is toggle based:
  - A request is issued by inverting `rv_req` while `rv_addr`, `rv_we` and `rv_din` are stable.
  - The request is complete when `rv_req_ack == rv_req`.
  - Read data is valid on the cycle after completion is observed.
  - Only one request is outstanding at a time.
- Word counter `wcnt` runs from 0 to LEN_BYTES/2−1. `rv_addr = BASE_ADDR + 2*wcnt`. Byte order is little-endian: the low byte goes first.
- States:
  - IDLE: go to RD_REQ or COLLECT0 on `i_start`, based on `i_dir`.
  - RD_REQ: toggle `rv_req` with `rv_we`=0, then go to RD_WAIT.
  - RD_WAIT: when acked, go to RD_CAP.
  - RD_CAP: latch `rv_dout`, then go to EMIT0.
  - EMIT0: present `rv_dout[7:0]` on the save stream; on handshake go to EMIT1.
  - EMIT1: present `rv_dout[15:8]`; on handshake go to RD_REQ with `wcnt`+1, or to DONE after the last word.
  - COLLECT0: take the low byte from the load stream, then go to COLLECT1.
  - COLLECT1: take the high byte, then go to WR_REQ.
  - WR_REQ: toggle `rv_req` with `rv_we`=1, then go to WR_WAIT.
  - WR_WAIT: when acked, go to COLLECT0 with `wcnt`+1, or to DONE after the last word.
  - DONE: pulse `o_done`, return to IDLE.
- Streams:
  - `o_tx_valid` is high only in EMIT0/EMIT1.
  - `o_rx_ready` is high only in COLLECT0/COLLECT1.
  - Data holds while valid is high and ready is low.
- Abort:
  - From EMIT* or COLLECT*: go to DONE next cycle.
  - From *_REQ or *_WAIT: go to DONE after the ack.
  - A partial word collected before abort is discarded, never written.
- `i_start` while busy is ignored.
- `i_dir` and `i_abort` are ignored in IDLE.
- Reset mid-transfer returns to IDLE immediately; the outstanding request is abandoned.
- Reset values:
  - All outputs 0.
  - `rv_req` is 0. The bench must reset the acknowledge source with it so that `rv_req_ack` is 0.

## Timing
- Save, with ack returning N cycles after the toggle and the sink always ready: 4+N cycles per word (REQ, N-cycle WAIT, CAP, EMIT0, EMIT1).
- Load, with the source always valid: 3+N cycles per word (COLLECT0, COLLECT1, WR_REQ, N-cycle WAIT).
- `o_busy` rises the cycle after `i_start` and falls with the `o_done` cycle.
- `o_wram_load_ongoing` rises and falls together with `o_busy`, during loads only.
- `o_done` is asserted for exactly one cycle, the cycle before IDLE.

## Configuration
- `WRAM_DMA_CHECKSUM_EN` defined:
  - `o_checksum` is a 16-bit wrapping sum of every byte handshaked in the current transfer.
  - It clears on `i_start` and is stable from `o_done` until the next start.
- Not defined: `o_checksum` is tied to 16'h0000 and the adder is not built.

## Test plan
- Save: memory model returns `rv_dout` = 16'hBEEF at 0x66000 and 16'h1234 at 0x66002; sink always ready -> save stream emits EF, BE, 34, 12; first `rv_addr` = 0x66000; `o_done` after 4096 words.
- Load: source supplies 0x00..0xFF repeating -> first write has `rv_din` = 16'h0100 at 0x66000; last write is at 0x67FFE with `rv_din` = 16'hFFFE; `o_wram_load_ongoing` is high throughout.
- Backpressure: sink ready toggles 1/0 each cycle and ack latency N = 7 -> no byte is lost or duplicated; at most one request is outstanding (`rv_req` toggles only after a matching ack).
- Abort: `i_abort` during WR_WAIT of word 5 -> exactly 6 writes seen, `o_done` pulses, `rv_req == rv_req_ack` in IDLE.
- Reset: `resetn` low in RD_WAIT -> all outputs 0 the same cycle; a subsequent start works from word 0.
- With `WRAM_DMA_CHECKSUM_EN`: a full save of all-0xFF memory -> `o_checksum` = 16'hE000 (8192×255 mod 65536).
